// File: rtl/cc_alu_seq.sv
// Sequential ALU with registered result, active-low condition-code outputs and valid/ready handshake.
// Define CC_ALU_SEQ_BARREL_EN for single-cycle barrel shifts; default is an iterative 1-bit/cycle shifter.
module cc_alu_seq #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic                               CC_ALUSEQ_CLOCK_50,
  input  logic                               CC_ALUSEQ_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_dataA_InBus,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_dataB_InBus,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_selection_InBus,
  input  logic                               CC_ALUSEQ_inValid_In,
  output logic                               CC_ALUSEQ_inReady_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_data_OutBus,
  output logic                               CC_ALUSEQ_outValid_Out,
  input  logic                               CC_ALUSEQ_outReady_In,
  output logic                               CC_ALUSEQ_SetCode_Out,
  output logic                               CC_ALUSEQ_overflow_OutLow,
  output logic                               CC_ALUSEQ_carry_OutLow,
  output logic                               CC_ALUSEQ_negative_OutLow,
  output logic                               CC_ALUSEQ_zero_OutLow
);

  localparam int W       = DATAWIDTH_BUS;
  localparam int SHAMT_W = $clog2(W);

  logic             clk;
  logic             rst;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [SHAMT_W-1:0] shamt;

  assign clk   = CC_ALUSEQ_CLOCK_50;
  assign rst   = CC_ALUSEQ_RESET_InHigh;
  assign a     = CC_ALUSEQ_dataA_InBus;
  assign b     = CC_ALUSEQ_dataB_InBus;
  assign shamt = CC_ALUSEQ_dataB_InBus[SHAMT_W-1:0];

`ifdef CC_ALU_SEQ_BARREL_EN
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state, state_nxt;

  logic [W:0]   add_ext;
  logic [W:0]   sub_ext;
  logic         add_v;
  logic         sub_v;
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic         cc_op;
  logic         accept;
  logic         in_ready;
  logic         out_valid;
  logic         load_alu;

  logic [W-1:0] result;
  logic         set_code;
  logic         psr_v, psr_c, psr_n, psr_z;

  // Subtraction is A + ~B + 1; its carry-out is the inverse of the borrow.
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign add_v   = (a[W-1] == b[W-1]) & (add_ext[W-1] != a[W-1]);
  assign sub_v   = (a[W-1] != b[W-1]) & (sub_ext[W-1] != a[W-1]);

`ifndef CC_ALU_SEQ_BARREL_EN
  logic               is_shift;
  logic               start_shift;
  logic               finish_shift;
  logic [W-1:0]       acc;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         shift_op;
`endif

  always_comb begin
    alu_res = a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    cc_op   = 1'b0;
`ifndef CC_ALU_SEQ_BARREL_EN
    is_shift = 1'b0;
`endif
    case (CC_ALUSEQ_selection_InBus)
      4'b0000: alu_res = a;
      4'b0001: alu_res = a | b;
      4'b0010: alu_res = a & b;
      4'b0011: begin
        alu_res = add_ext[W-1:0];
        alu_c   = add_ext[W];
        alu_v   = add_v;
        cc_op   = 1'b1;
      end
      4'b0100: alu_res = a ^ b;
      4'b0101: begin
        alu_res = a & b;
        cc_op   = 1'b1;
      end
      4'b0110: begin
`ifdef CC_ALU_SEQ_BARREL_EN
        alu_res = a << shamt;
`else
        is_shift = 1'b1;
`endif
      end
      4'b0111: begin
        alu_res = ~(a | b);
        cc_op   = 1'b1;
      end
      4'b1000: alu_res = add_ext[W-1:0];
      4'b1001: alu_res = sub_ext[W-1:0];
      4'b1010: alu_res = a + {{(W-1){1'b0}}, 1'b1};
      4'b1011: alu_res = a - {{(W-1){1'b0}}, 1'b1};
      4'b1100: begin
`ifdef CC_ALU_SEQ_BARREL_EN
        alu_res = a >> shamt;
`else
        is_shift = 1'b1;
`endif
      end
      4'b1101: begin
        alu_res = sub_ext[W-1:0];
        alu_c   = ~sub_ext[W];
        alu_v   = sub_v;
        cc_op   = 1'b1;
      end
      4'b1110: begin
`ifdef CC_ALU_SEQ_BARREL_EN
        alu_res = $unsigned($signed(a) >>> shamt);
`else
        is_shift = 1'b1;
`endif
      end
      default: alu_res = a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_alu  = 1'b0;
`ifndef CC_ALU_SEQ_BARREL_EN
    start_shift  = 1'b0;
    finish_shift = 1'b0;
`endif
    case (state)
      IDLE: in_ready = 1'b1;
`ifndef CC_ALU_SEQ_BARREL_EN
      SHIFT: begin
        if (cnt == '0) begin
          state_nxt    = DONE;
          finish_shift = 1'b1;
        end
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready  = CC_ALUSEQ_outReady_In;
        if (CC_ALUSEQ_outReady_In) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = CC_ALUSEQ_inValid_In & in_ready;
    if (accept) begin
      state_nxt = DONE;
      load_alu  = 1'b1;
`ifndef CC_ALU_SEQ_BARREL_EN
      if (is_shift) begin
        state_nxt   = SHIFT;
        load_alu    = 1'b0;
        start_shift = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      set_code <= 1'b0;
      psr_v    <= 1'b0;
      psr_c    <= 1'b0;
      psr_n    <= 1'b0;
      psr_z    <= 1'b0;
    end else if (load_alu) begin
      result   <= alu_res;
      set_code <= cc_op;
      if (cc_op) begin
        psr_v <= alu_v;
        psr_c <= alu_c;
        psr_n <= alu_res[W-1];
        psr_z <= (alu_res == '0);
      end
`ifndef CC_ALU_SEQ_BARREL_EN
    end else if (finish_shift) begin
      result   <= acc;
      set_code <= 1'b0;
`endif
    end
  end

`ifndef CC_ALU_SEQ_BARREL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      shift_op <= 4'b0000;
    end else if (start_shift) begin
      acc      <= a;
      cnt      <= shamt;
      shift_op <= CC_ALUSEQ_selection_InBus[3:0];
    end else if (state == SHIFT && cnt != '0) begin
      cnt <= cnt - 1'b1;
      case (shift_op)
        4'b0110: acc <= {acc[W-2:0], 1'b0};
        4'b1100: acc <= {1'b0, acc[W-1:1]};
        default: acc <= {acc[W-1], acc[W-1:1]};
      endcase
    end
  end
`endif

  assign CC_ALUSEQ_inReady_Out     = in_ready;
  assign CC_ALUSEQ_outValid_Out    = out_valid;
  assign CC_ALUSEQ_data_OutBus     = result;
  assign CC_ALUSEQ_SetCode_Out     = set_code;
  assign CC_ALUSEQ_overflow_OutLow = ~psr_v;
  assign CC_ALUSEQ_carry_OutLow    = ~psr_c;
  assign CC_ALUSEQ_negative_OutLow = ~psr_n;
  assign CC_ALUSEQ_zero_OutLow     = ~psr_z;

endmodule

// File: tb/tb_cc_alu_seq.sv
// Randomized bench for cc_alu_seq against an arithmetic reference model with a tracked PSR.
module tb_cc_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        set_code;
  logic        ovf_n, carry_n, neg_n, zero_n;

  int checks = 0;
  int errors = 0;

  bit m_v, m_c, m_n, m_z;

  cc_alu_seq #(.DATAWIDTH_BUS(32), .DATAWIDTH_ALU_SELECTION(4)) dut (
    .CC_ALUSEQ_CLOCK_50        (clk),
    .CC_ALUSEQ_RESET_InHigh    (rst),
    .CC_ALUSEQ_dataA_InBus     (a),
    .CC_ALUSEQ_dataB_InBus     (b),
    .CC_ALUSEQ_selection_InBus (sel),
    .CC_ALUSEQ_inValid_In      (in_valid),
    .CC_ALUSEQ_inReady_Out     (in_ready),
    .CC_ALUSEQ_data_OutBus     (data),
    .CC_ALUSEQ_outValid_Out    (out_valid),
    .CC_ALUSEQ_outReady_In     (out_ready),
    .CC_ALUSEQ_SetCode_Out     (set_code),
    .CC_ALUSEQ_overflow_OutLow (ovf_n),
    .CC_ALUSEQ_carry_OutLow    (carry_n),
    .CC_ALUSEQ_negative_OutLow (neg_n),
    .CC_ALUSEQ_zero_OutLow     (zero_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_shift_op(input logic [3:0] op);
    return (op == 4'h6) || (op == 4'hC) || (op == 4'hE);
  endfunction

  // Reference: result from plain arithmetic; PSR updated only by cc ops.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output bit cc);
    longint sx, sy, s;
    logic [32:0] wide;
    int sh;
    bit v, c;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    cc = 0; v = 0; c = 0;
    case (op)
      4'h0: r = x;
      4'h1: r = x | y;
      4'h2: r = x & y;
      4'h3: begin
        wide = {1'b0, x} + {1'b0, y};
        r = wide[31:0]; c = wide[32];
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cc = 1;
      end
      4'h4: r = x ^ y;
      4'h5: begin r = x & y; cc = 1; end
      4'h6: r = x << sh;
      4'h7: begin r = ~(x | y); cc = 1; end
      4'h8: r = x + y;
      4'h9: r = x - y;
      4'hA: r = x + 32'd1;
      4'hB: r = x - 32'd1;
      4'hC: r = x >> sh;
      4'hD: begin
        r = x - y; c = (x < y);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cc = 1;
      end
      4'hE: r = $unsigned($signed(x) >>> sh);
      default: r = x;
    endcase
    if (cc) begin
      m_v = v; m_c = c; m_n = r[31]; m_z = (r == 32'd0);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".ovf_n"},   {31'd0, ovf_n},   {31'd0, ~m_v});
    check({tag, ".carry_n"}, {31'd0, carry_n}, {31'd0, ~m_c});
    check({tag, ".neg_n"},   {31'd0, neg_n},   {31'd0, ~m_n});
    check({tag, ".zero_n"},  {31'd0, zero_n},  {31'd0, ~m_z});
  endtask

  // Called between edges with the block in IDLE or DONE and out_ready high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    bit ecc;
    int lat, elat;
    model(op, x, y, er, ecc);
    elat = 1;
`ifndef CC_ALU_SEQ_BARREL_EN
    if (is_shift_op(op)) elat = int'(y[4:0]) + 2;
`endif
    sel = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sel = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("data", data, er);
    check("set_code", {31'd0, set_code}, {31'd0, ecc});
    check_flags("op");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".data"},      data,               32'd0);
    check({tag, ".set_code"},  {31'd0, set_code},  32'd0);
    check_flags(tag);
  endtask

  initial begin
    logic [31:0] er, held;
    bit ecc;
    logic [31:0] x, y;
    logic [3:0] op;

    m_v = 0; m_c = 0; m_n = 0; m_z = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_state("reset");

    run_op(4'h3, 32'h7FFFFFFF, 32'd1);
    run_op(4'hD, 32'd5, 32'd5);
    run_op(4'h8, 32'd1, 32'd1);
    run_op(4'h6, 32'd1, 32'd31);
    run_op(4'hE, 32'h80000000, 32'h24);
    run_op(4'hC, 32'hA5, 32'h20);
    run_op(4'hF, 32'h1234, 32'h0);
    run_op(4'h7, 32'hFFFF0000, 32'h0000FFFF);

    // Backpressure: hold result for five cycles, then issue on the release cycle.
    out_ready = 1'b1;
    @(posedge clk); #1;
    model(4'h3, 32'hFFFFFFFF, 32'd1, er, ecc);
    sel = 4'h3; a = 32'hFFFFFFFF; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    #1 check("bp.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = er;
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.data", data, held);
      check("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
      check_flags("bp");
      @(posedge clk); #1;
    end
    model(4'h4, 32'hF0F0F0F0, 32'hFF00FF00, er, ecc);
    sel = 4'h4; a = 32'hF0F0F0F0; b = 32'hFF00FF00; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("bp.release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.next_valid", {31'd0, out_valid}, 32'd1);
    check("bp.next_data", data, er);

    // Reset pulse in the middle of a long shift.
    sel = 4'h6; a = 32'd1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    m_v = 0; m_c = 0; m_n = 0; m_z = 0;
    #1 check_reset_state("midreset");
    run_op(4'h3, 32'd3, 32'd4);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: x = 32'h7FFFFFFF;
        1: x = 32'h80000000;
        2: x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 5) == 0) ? x : $urandom;
      run_op(op, x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
